// File: rtl/pin_lock_ctrl.sv
// PIN lock sequencing controller.
// Steps the digit index through a 4-digit entry and latches a sticky mismatch.
// After the 4th digit it either opens the lock for a timed window or records a failure.
// Too many consecutive failures impose a timed lockout.
module pin_lock_ctrl #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter,
  input  logic       cancel,
  input  logic       correct_digit,
  output logic [1:0] digit_idx,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_count,
  output logic       error
);

  localparam int unsigned MaxCycles =
      (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  // The timer only ever holds N-1, so clog2(N) bits are enough.
  localparam int unsigned TimerW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] UnlockLoad  = TimerW'(UNLOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]        MaxTriesV   = 2'(MAX_TRIES);
  localparam logic [2:0]        MaxTriesW   = 3'(MAX_TRIES);

  localparam logic [1:0] StEntry   = 2'd0;
  localparam logic [1:0] StOpen    = 2'd1;
  localparam logic [1:0] StLockout = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              mismatch_q, mismatch_d;
  logic [1:0]        fail_q, fail_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_out_q, locked_out_d;
  logic              error_q, error_d;
  logic              entry_bad;

  // The verdict counts the final digit's check along with any earlier mismatch.
  assign entry_bad = mismatch_q | ~correct_digit;

  // Next-state logic for the entry / open / lockout sequencing.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    fail_d       = fail_q;
    timer_d      = timer_q;
    unlocked_d   = unlocked_q;
    locked_out_d = locked_out_q;
    error_d      = 1'b0;

    case (state_q)
      StEntry: begin
        if (cancel) begin
          // Cancel wins over a simultaneous enter.
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
        end else if (enter) begin
          if (idx_q != 2'd3) begin
            idx_d      = idx_q + 2'd1;
            mismatch_d = mismatch_q | ~correct_digit;
          end else begin
            idx_d      = 2'd0;
            mismatch_d = 1'b0;
            if (!entry_bad) begin
              state_d    = StOpen;
              unlocked_d = 1'b1;
              fail_d     = 2'd0;
              timer_d    = UnlockLoad;
            end else begin
              error_d = 1'b1;
              if (({1'b0, fail_q} + 3'd1) >= MaxTriesW) begin
                state_d      = StLockout;
                locked_out_d = 1'b1;
                fail_d       = MaxTriesV;
                timer_d      = LockoutLoad;
              end else begin
                fail_d = fail_q + 2'd1;
              end
            end
          end
        end
      end

      StOpen: begin
        if (timer_q == '0) begin
          state_d    = StEntry;
          unlocked_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StLockout: begin
        if (timer_q == '0) begin
          state_d      = StEntry;
          locked_out_d = 1'b0;
          fail_d       = 2'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d      = StEntry;
        idx_d        = 2'd0;
        mismatch_d   = 1'b0;
        fail_d       = 2'd0;
        timer_d      = '0;
        unlocked_d   = 1'b0;
        locked_out_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, including lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEntry;
      idx_q        <= 2'd0;
      mismatch_q   <= 1'b0;
      fail_q       <= 2'd0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      fail_q       <= fail_d;
      timer_q      <= timer_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      error_q      <= error_d;
    end
  end

  assign digit_idx  = idx_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign fail_count = fail_q;
  assign error      = error_q;

endmodule
